// File: rtl/econet_pkg.sv
// Shared types, constants and CRC-16/HDLC step for the Econet receive path.
// Pure declarations, no logic of its own.
package econet_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ADDR    = 2'd1,
    ST_DATA    = 2'd2,
    ST_DISCARD = 2'd3
  } rx_state_t;

  localparam logic [15:0] CRC_INIT      = 16'hFFFF;
  localparam logic [15:0] CRC_POLY      = 16'h8408;
  localparam logic [15:0] CRC_GOOD      = 16'hF0B8;
  localparam int          MIN_FRAME_LEN = 6;
  localparam int          LEN_W         = 11;

  typedef struct packed {
    logic       last;
    logic [7:0] dat;
  } fifo_ent_t;

  // Reflected CRC, LSB first, one whole byte per call.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] b);
    logic [15:0] c;
    c = crc_in ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/econet_rx_fifo.sv
// Synchronous FIFO with registered storage; head visible the cycle after write.
// Push is refused when full unless a pop lands in the same cycle.
module econet_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9
) (
  input  logic             econet_clk,
  input  logic             reset_n,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop_rdy & ~empty;
  assign do_push  = push_vld & (~full | do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge econet_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/econet_rx_frame.sv
// Econet frame receiver: address filter, CRC check, byte FIFO, per-frame status.
// Bytes trail the PHY by one held byte; out_valid/out_ready backpressure, overflow drops the frame.
module econet_rx_frame
  import econet_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_LEN    = 2047
) (
  input  logic             econet_clk,
  input  logic             reset_n,
  input  logic [7:0]       my_station,
  input  logic [7:0]       rx_data,
  input  logic             rx_strobe,
  input  logic             rx_frame_start,
  input  logic             rx_frame_end,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             stat_done,
  output logic             stat_ok,
  output logic             stat_crc_err,
  output logic             stat_overrun,
  output logic             stat_runt,
  output logic             stat_abort,
  output logic [LEN_W-1:0] stat_len
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  rx_state_t        state, state_nxt;
  logic             strobe_q;
  logic             acc;
  logic [15:0]      crc;
  logic [LEN_W-1:0] len, len_inc;
  logic [7:0]       hold_dat;
  logic             hold_vld;
  logic             end_pend, end_pend_nxt;
  logic             addr_hit, pop, space, fifo_full, fifo_empty;
  logic             byte_take, close_evt;
  logic             push_vld;
  fifo_ent_t        push_ent, head_ent;
  logic             fin, fin_ok, fin_crc, fin_runt, fin_ovr, fin_abort;

  assign acc       = rx_strobe & ~strobe_q;
  assign addr_hit  = (rx_data == my_station) | (rx_data == 8'hFF);
  assign pop       = out_valid & out_ready;
  assign space     = ~fifo_full | pop;
  assign len_inc   = (len >= LEN_MAX) ? len : len + 1'b1;
  // Closing flag either arrives now or was deferred by a byte that came with it.
  assign close_evt = end_pend | (rx_frame_end & ~acc);
  assign byte_take = acc & ~rx_frame_start &
                     ((state == ST_ADDR) | ((state == ST_DATA) & ~end_pend & space));

  always_ff @(posedge econet_clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (rx_frame_start) begin
      state_nxt = ST_ADDR;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_IDLE;
        ST_ADDR: begin
          if (acc && addr_hit)   state_nxt = ST_DATA;
          else if (rx_frame_end) state_nxt = ST_IDLE;
          else if (acc)          state_nxt = ST_DISCARD;
        end
        ST_DATA: begin
          if (close_evt)         state_nxt = space ? ST_IDLE : ST_DISCARD;
          else if (acc && !space) state_nxt = ST_DISCARD;
        end
        ST_DISCARD: if (rx_frame_end) state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    push_vld     = 1'b0;
    push_ent     = '{last: 1'b0, dat: hold_dat};
    end_pend_nxt = 1'b0;
    fin          = 1'b0;
    fin_crc      = 1'b0;
    fin_runt     = 1'b0;
    fin_ovr      = 1'b0;
    fin_abort    = 1'b0;
    case (state)
      ST_ADDR: end_pend_nxt = acc & addr_hit & rx_frame_end & ~rx_frame_start;
      ST_DATA: begin
        if (rx_frame_start && !end_pend) begin
          push_vld      = space & hold_vld;
          push_ent.last = 1'b1;
          fin           = 1'b1;
          fin_abort     = 1'b1;
          fin_ovr       = ~space;
        end else if (close_evt) begin
          push_vld      = space & hold_vld;
          push_ent.last = 1'b1;
          fin           = 1'b1;
          fin_ovr       = ~space;
          fin_crc       = (crc != CRC_GOOD);
          fin_runt      = (len < LEN_W'(MIN_FRAME_LEN));
        end else if (acc) begin
          push_vld = space & hold_vld;
          if (!space) begin
            fin     = 1'b1;
            fin_ovr = 1'b1;
          end else begin
            // Byte and closing flag together: byte becomes held, flushed as last next cycle.
            end_pend_nxt = rx_frame_end;
          end
        end
      end
      default: ;
    endcase
    fin_ok = fin & ~(fin_crc | fin_runt | fin_ovr | fin_abort);
  end

  always_ff @(posedge econet_clk or negedge reset_n) begin
    if (!reset_n) begin
      strobe_q <= 1'b0;
      crc      <= CRC_INIT;
      len      <= '0;
      hold_dat <= '0;
      hold_vld <= 1'b0;
      end_pend <= 1'b0;
    end else begin
      strobe_q <= rx_strobe;
      end_pend <= end_pend_nxt;
      if (rx_frame_start) begin
        crc      <= CRC_INIT;
        len      <= '0;
        hold_vld <= 1'b0;
      end else begin
        if (byte_take) begin
          crc <= crc16_byte(crc, rx_data);
          len <= len_inc;
        end
        if (byte_take && (state == ST_DATA || addr_hit)) begin
          hold_dat <= rx_data;
          hold_vld <= 1'b1;
        end else if (state_nxt != ST_DATA) begin
          hold_vld <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge econet_clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_done    <= 1'b0;
      stat_ok      <= 1'b0;
      stat_crc_err <= 1'b0;
      stat_overrun <= 1'b0;
      stat_runt    <= 1'b0;
      stat_abort   <= 1'b0;
      stat_len     <= '0;
    end else begin
      stat_done <= fin;
      if (fin) begin
        stat_ok      <= fin_ok;
        stat_crc_err <= fin_crc;
        stat_overrun <= fin_ovr;
        stat_runt    <= fin_runt;
        stat_abort   <= fin_abort;
        stat_len     <= len;
      end else if (rx_frame_start) begin
        stat_ok      <= 1'b0;
        stat_crc_err <= 1'b0;
        stat_overrun <= 1'b0;
        stat_runt    <= 1'b0;
        stat_abort   <= 1'b0;
      end
    end
  end

  econet_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fifo_ent_t))
  ) u_fifo (
    .econet_clk (econet_clk),
    .reset_n    (reset_n),
    .push_vld   (push_vld),
    .push_dat   (push_ent),
    .pop_rdy    (pop),
    .head_dat   (head_ent),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign out_data  = head_ent.dat;
  assign out_last  = head_ent.last;

endmodule
